// File: rtl/fast2slow_tx.sv
// rtl/fast2slow_tx.sv - fast-side pulse-to-4-phase req/ack sender with saturating pending counter
module fast2slow_tx #(
    parameter int SYNC_STAGES = 2,
    parameter int CNT_W       = 4
) (
    input  logic f_clk,
    input  logic frst,
    input  logic i_sgl,
    input  logic i_ack,
    output logic o_req,
    output logic o_busy,
    output logic o_done,
    output logic o_drop
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] REQ  = 2'd1;
    localparam logic [1:0] REL  = 2'd2;

    localparam logic [CNT_W-1:0] PEND_MAX  = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] PEND_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] PEND_ZERO = {CNT_W{1'b0}};

    logic [SYNC_STAGES-1:0] r_sync;
    logic [1:0]             r_state;
    logic [CNT_W-1:0]       r_pend;
    logic                   r_req;
    logic                   r_done;
    logic                   r_drop;

    logic                   w_ack_s;
    logic                   w_pend_nz;
    logic [1:0]             w_state_n;
    logic [CNT_W-1:0]       w_pend_n;
    logic                   w_req_n;
    logic                   w_done_n;
    logic                   w_drop_n;

    assign w_ack_s   = r_sync[SYNC_STAGES-1];
    assign w_pend_nz = (r_pend != PEND_ZERO);

    always_ff @(posedge f_clk or posedge frst) begin
        if (frst) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], i_ack};
        end
    end

    always_comb begin
        w_state_n = r_state;
        w_pend_n  = r_pend;
        w_req_n   = r_req;
        w_done_n  = 1'b0;
        w_drop_n  = 1'b0;
        case (r_state)
            IDLE: begin
                w_req_n = 1'b0;
                if (i_sgl || w_pend_nz) begin
                    w_state_n = REQ;
                    w_req_n   = 1'b1;
                end
                // A pulse arriving with work pending consumes one and queues one: net zero.
                if (!i_sgl && w_pend_nz) begin
                    w_pend_n = r_pend - PEND_ONE;
                end
            end
            REQ: begin
                w_req_n = 1'b1;
                if (w_ack_s) begin
                    w_state_n = REL;
                    w_req_n   = 1'b0;
                end
            end
            REL: begin
                w_req_n = 1'b0;
                if (!w_ack_s) begin
                    w_state_n = IDLE;
                    w_done_n  = 1'b1;
                end
            end
            default: begin
                w_state_n = IDLE;
                w_req_n   = 1'b0;
            end
        endcase
        if ((r_state == REQ || r_state == REL) && i_sgl) begin
            if (r_pend == PEND_MAX) begin
                w_drop_n = 1'b1;
            end else begin
                w_pend_n = r_pend + PEND_ONE;
            end
        end
    end

    always_ff @(posedge f_clk or posedge frst) begin
        if (frst) begin
            r_state <= IDLE;
            r_pend  <= PEND_ZERO;
            r_req   <= 1'b0;
            r_done  <= 1'b0;
            r_drop  <= 1'b0;
        end else begin
            r_state <= w_state_n;
            r_pend  <= w_pend_n;
            r_req   <= w_req_n;
            r_done  <= w_done_n;
            r_drop  <= w_drop_n;
        end
    end

    assign o_req  = r_req;
    assign o_done = r_done;
    assign o_drop = r_drop;
    assign o_busy = (r_state != IDLE) | w_pend_nz;

endmodule

// File: doc/fast2slow_tx.md
Name: fast2slow_tx

Overview:
- Fast-clock-side sender that carries single-cycle control pulses from the fast clock region to a slow clock region.
- Each accepted pulse becomes one 4-phase req/ack handshake; o_req is a registered level that the slow side samples with its own synchronizer.
- i_ack is asynchronous and is synchronized here before use.
- Pulses that arrive while a handshake is in flight are queued in a saturating pending counter. None are lost until the counter saturates.

Parameters:
SYNC_STAGES, 2, number of f_clk flops in the i_ack synchronizer (legal range 2 to 4).
CNT_W, 4, width of the pending-pulse counter; maximum queued pulses = 2^CNT_W-1.

Ports:
f_clk  input  1  fast clock; all logic on its rising edge.
frst  input  1  asynchronous, active-high reset.
i_sgl  input  1  single-cycle control pulse from the fast region; one handshake per cycle it is high.
i_ack  input  1  acknowledge level from the slow region; asynchronous to f_clk.
o_req  output  1  request level to the slow region; driven directly from a flop.
o_busy  output  1  high while a handshake is in flight or pulses are pending.
o_done  output  1  one-cycle pulse when a handshake fully completes.
o_drop  output  1  one-cycle pulse when an i_sgl is discarded because the counter is saturated.

Behaviour:
- Reset (async assert, sync deassert by integration): state=IDLE, pend=0, all sync flops=0, o_req=0, o_done=0, o_drop=0, o_busy=0.
- ack_s = last stage of the SYNC_STAGES-deep synchronizer on i_ack. The FSM uses only ack_s.
- o_busy = (state!=IDLE) | (pend!=0); combinational from flops only.
- FSM states: IDLE, REQ, REL.
- IDLE:
  - o_req=0.
  - If i_sgl=1 or pend!=0: next state is REQ, and o_req=1 from the next cycle.
  - pend update in IDLE: i_sgl=1 and pend=0 → pend stays 0. i_sgl=0 and pend!=0 → pend-1. i_sgl=1 and pend!=0 → pend unchanged (consume one, queue one).
- REQ:
  - o_req=1.
  - When ack_s=1: next state is REL, and o_req=0 from the next cycle.
- REL:
  - o_req=0.
  - When ack_s=0: next state is IDLE, and o_done=1 for exactly the first cycle spent in IDLE.
  - A new handshake may start in that same first IDLE cycle if pend!=0 or i_sgl=1. The earliest o_req re-assertion is therefore one cycle after o_done.
- Pulse queuing in REQ and REL:
  - i_sgl=1 with pend<2^CNT_W-1 → pend+1.
  - i_sgl=1 with pend=2^CNT_W-1 → pend unchanged, and o_drop=1 for the next cycle.
- Latency:
  - i_sgl in cycle 0 with state=IDLE, pend=0 → o_req=1 in cycle 1.
  - i_ack first sampled high at edge k → o_req=0 after edge k+SYNC_STAGES.
  - i_ack first sampled low at edge m → o_done=1 after edge m+SYNC_STAGES.
- Invariant: number of o_req rising edges = number of i_sgl pulses − number of o_drop pulses, once o_busy returns to 0.
- i_ack misbehaviour:
  - A rise of i_ack while in IDLE is ignored.
  - A fall of i_ack while in REQ before it was ever high is ignored.
  - If i_ack is stuck high, the FSM holds in REL indefinitely and o_busy stays 1.
- Reset mid-operation: o_req drops asynchronously and pending pulses are discarded. The slow side must treat a req fall without its own ack as an aborted transfer.
- No combinational path from any input to any output.

Test Plan:
- Single pulse: i_sgl at cycle 0, responder raises i_ack 5 cycles after it sees o_req and drops it 5 cycles after o_req falls, SYNC_STAGES=2 → o_req=1 at cycle 1; o_req=0 two edges after i_ack is sampled high; exactly one o_done; o_busy returns to 0.
- Burst: 4 i_sgl pulses on consecutive cycles starting from IDLE → exactly 4 complete handshakes, pend peaks at 3, 4 o_done pulses, 0 o_drop.
- Saturation: CNT_W=2, 6 pulses while in REQ with i_ack held low → pend=3, o_drop pulses exactly 3 times; after release, exactly 3 more handshakes occur.
- Simultaneous events: i_sgl high in the o_done cycle with pend=1 → pend stays 1, o_req=1 next cycle; 2 further handshakes complete in total.
- Reset mid-REQ: assert frst while o_req=1 and pend=2 → o_req=0 and o_busy=0 immediately (async); after release, no handshake starts without a new i_sgl.
- Stuck ack: i_ack held high throughout → one o_req rise then fall; FSM holds in REL, o_busy=1, no o_done until i_ack falls.
